// File: rtl/fir_spi_pkg.sv
// Shared constants for the FIR SPI front end: opcodes, FSM states, status bit
// positions and the filter handshake timeout.
package fir_spi_pkg;

    localparam logic [7:0] OP_LOAD_COEFF = 8'h01;
    localparam logic [7:0] OP_SAMPLE     = 8'h02;
    localparam logic [7:0] OP_READ       = 8'h03;
    localparam logic [7:0] OP_CLR_STATUS = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_CAPTURE
    } state_t;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_ERR       = 1;
    localparam int unsigned STAT_ONE_K     = 2;
    localparam int unsigned STAT_OVERRUN   = 3;
    localparam int unsigned STAT_FRAME_ERR = 4;
    localparam int unsigned STAT_TIMEOUT   = 5;

    localparam int unsigned TIMEOUT_CLKS = 16;

endpackage

// File: rtl/sync_high.sv
// Two-flop synchronizer for one asynchronous input; the reset value is the
// input's idle level so no false edge is seen while reset is applied.
module sync_high #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fir_spi_frontend.sv
// SPI slave that decodes host frames into coefficient/sample strobes for a FIR
// filter, runs the modwait handshake and returns {status, result} on readback.
module fir_spi_frontend
    import fir_spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic [15:0] sample_data,
    output logic [15:0] fir_coefficient,
    output logic        data_ready,
    output logic        load_coeff,
    input  logic        modwait,
    input  logic [15:0] fir_out,
    input  logic        err,
    input  logic        one_k_samples
);

    localparam int unsigned CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);
    localparam logic [4:0]    TIMER_LAST = 5'(TIMEOUT_CLKS - 1);

    logic sclk_s, ss_s, mosi_s;
    logic sclk_d, ss_d;
    logic [1:0] arm_cnt;
    logic armed;
    logic frame_active;
    logic [CW-1:0] bit_cnt;
    logic [FRAME_BITS-1:0] rx_sr, tx_sr;
    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [7:0]  opcode;
    logic [15:0] payload;
    logic frame_ok, is_start, start, drop, clr, bad;

    state_t state, state_next;
    logic [4:0]  timer;
    logic        cmd_is_sample;
    logic        timeout_hit;
    logic [15:0] result;
    logic        err_q, one_k_q, overrun_q, frame_err_q, timeout_q;
    logic [7:0]  status;

    sync_high #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    sync_high #(.RESET_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .d(ss_n), .q(ss_s));
    sync_high #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    // Edges are ignored until the synchronizers have flushed their reset values,
    // so a select already held low at reset release never starts a frame.
    assign armed     = (arm_cnt == 2'd3);
    assign ss_fall   = armed & ss_d & ~ss_s;
    assign ss_rise   = armed & frame_active & ~ss_d & ss_s;
    assign sclk_rise = armed & frame_active & ~ss_s & ~sclk_d & sclk_s;
    assign sclk_fall = armed & frame_active & ~ss_s & sclk_d & ~sclk_s;

    assign miso = tx_sr[FRAME_BITS-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d       <= 1'b0;
            ss_d         <= 1'b1;
            arm_cnt      <= '0;
            frame_active <= 1'b0;
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
        end else begin
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
            if (!armed) arm_cnt <= arm_cnt + 2'd1;
            if (ss_fall) begin
                frame_active <= 1'b1;
                bit_cnt      <= '0;
                tx_sr        <= FRAME_BITS'({status, result}) << (FRAME_BITS - 24);
            end else if (ss_rise) begin
                frame_active <= 1'b0;
            end
            if (sclk_rise) begin
                rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_s};
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall) tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_comb begin
        opcode   = rx_sr[FRAME_BITS-1 -: 8];
        payload  = rx_sr[15:0];
        frame_ok = ss_rise && (bit_cnt == CNT_FULL);
        is_start = frame_ok && (opcode == OP_LOAD_COEFF || opcode == OP_SAMPLE);
        start    = is_start && (state == ST_IDLE);
        drop     = is_start && (state != ST_IDLE);
        clr      = frame_ok && (opcode == OP_CLR_STATUS);
        bad      = ss_rise && ((bit_cnt != CNT_FULL) ||
                   !(opcode inside {OP_LOAD_COEFF, OP_SAMPLE, OP_READ, OP_CLR_STATUS}));
    end

    always_comb begin
        status                 = '0;
        status[STAT_BUSY]      = (state != ST_IDLE);
        status[STAT_ERR]       = err_q;
        status[STAT_ONE_K]     = one_k_q;
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_TIMEOUT]   = timeout_q;
    end

    always_comb begin
        state_next  = state;
        data_ready  = 1'b0;
        load_coeff  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: if (start) state_next = ST_STROBE;
            ST_STROBE: begin
                data_ready = cmd_is_sample;
                load_coeff = !cmd_is_sample;
                if (modwait) begin
                    state_next = ST_WAIT_HI;
                end else if (timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (modwait) begin
                    state_next = ST_WAIT_LO;
                end else if (timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_WAIT_LO: if (!modwait) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            timer           <= '0;
            cmd_is_sample   <= 1'b0;
            sample_data     <= '0;
            fir_coefficient <= '0;
            result          <= '0;
            err_q           <= 1'b0;
            one_k_q         <= 1'b0;
            overrun_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            state <= state_next;
            // Timer restarts on every state change and only runs while waiting
            // for the filter to raise modwait.
            if (state_next != state) begin
                timer <= '0;
            end else if (state == ST_STROBE || state == ST_WAIT_HI) begin
                timer <= timer + 5'd1;
            end
            if (start) begin
                cmd_is_sample <= (opcode == OP_SAMPLE);
                if (opcode == OP_SAMPLE) sample_data     <= payload;
                else                     fir_coefficient <= payload;
            end
            if (clr) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (drop)        overrun_q   <= 1'b1;
            if (bad)         frame_err_q <= 1'b1;
            if (timeout_hit) timeout_q   <= 1'b1;
            if (state == ST_CAPTURE) begin
                err_q   <= err;
                one_k_q <= one_k_samples;
                if (cmd_is_sample) result <= fir_out;
            end
        end
    end

endmodule
